// File: rtl/adf4030_trig_pkg.sv
// Shared types and helpers for the ADF4030 trigger generator.
//   trig_state_t : per-channel trigger FSM state, as reported to the regmap
//   TRIG_STATE_W : width of the reported state field
//   phase_cnt_w  : width of the shared phase counter / phase compare
package adf4030_trig_pkg;

    localparam int unsigned TRIG_STATE_W = 3;

    typedef enum logic [TRIG_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_COUNT = 3'd2,
        ST_FIRE  = 3'd3,
        ST_ERROR = 3'd5
    } trig_state_t;

    // One extra bit so a full BSYNC period (2*ratio) fits in the counter.
    function automatic int unsigned phase_cnt_w(input int unsigned phase_width);
        return phase_width + 1;
    endfunction

endpackage

// File: rtl/axi_adf4030_trig_channel.sv
// One trigger channel: arms on a request, waits for the next BSYNC tick,
// fires a single-cycle pulse when the shared phase counter hits its phase.
//   clk, rstn   : core clock, async active-low reset
//   req         : shared trigger request (single-cycle)
//   tick        : BSYNC period-start pulse
//   phase_cnt   : shared phase counter (cycles since last tick)
//   phase       : firing offset for this channel
//   en          : channel enable
//   ready       : BSYNC valid
//   ratio_valid : BSYNC ratio is non-zero
//   trig_out    : registered trigger pulse
//   state       : current FSM state
module axi_adf4030_trig_channel
    import adf4030_trig_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          req,
    input  logic                          tick,
    input  logic [PHASE_WIDTH:0]          phase_cnt,
    input  logic [PHASE_WIDTH-1:0]        phase,
    input  logic                          en,
    input  logic                          ready,
    input  logic                          ratio_valid,
    output logic                          trig_out,
    output logic [TRIG_STATE_W-1:0]       state
);

    trig_state_t r_state;
    trig_state_t w_next;
    logic        r_trig_out;
    logic        w_match;
    logic        w_can_arm;

    assign w_match   = (phase_cnt == {1'b0, phase});
    assign w_can_arm = req && ready && ratio_valid;

    // A match coinciding with the next tick still fires: the phase is
    // inside the period, the counter simply reached it on the last cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (en && w_can_arm) w_next = ST_ARMED;
            ST_ARMED: begin
                if (!en)         w_next = ST_IDLE;
                else if (!ready) w_next = ST_ERROR;
                else if (tick)   w_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (!en)          w_next = ST_IDLE;
                else if (!ready)  w_next = ST_ERROR;
                else if (w_match) w_next = ST_FIRE;
                else if (tick)    w_next = ST_ERROR;
            end
            ST_FIRE:  w_next = ST_IDLE;
            ST_ERROR: begin
                if (!en)            w_next = ST_IDLE;
                else if (w_can_arm) w_next = ST_ARMED;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_trig_out <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_trig_out <= (w_next == ST_FIRE);
        end
    end

    assign trig_out = r_trig_out;
    assign state    = r_state;

endmodule

// File: rtl/axi_adf4030_trig_gen.sv
// ADF4030 trigger generator. Edge-detects the external and manual trigger
// sources, selects one as the shared request, runs the shared BSYNC phase
// counter and instantiates one trigger channel per output.
//   clk, rstn          : core clock, async active-low reset
//   bsync_ready/tick   : BSYNC valid and period-start pulse
//   bsync_ratio        : BSYNC half-period in clk cycles (0 = invalid)
//   ext_trig           : external trigger request
//   manual_trig        : software trigger level
//   select_trig        : 1 = manual_trig, 0 = ext_trig
//   trig_channel_en    : per-channel enable
//   trig_channel_phase : per-channel firing offset from period start
//   trig_out           : per-channel trigger pulses
//   trig_state         : per-channel FSM state
module axi_adf4030_trig_gen
    import adf4030_trig_pkg::*;
#(
    parameter int unsigned CHANNEL_COUNT = 1,
    parameter int unsigned PHASE_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     bsync_ready,
    input  logic                     bsync_tick,
    input  logic [PHASE_WIDTH-1:0]   bsync_ratio,
    input  logic                     ext_trig,
    input  logic                     manual_trig,
    input  logic                     select_trig,
    input  logic [CHANNEL_COUNT-1:0] trig_channel_en,
    input  logic [PHASE_WIDTH-1:0]   trig_channel_phase [CHANNEL_COUNT],
    output logic [CHANNEL_COUNT-1:0] trig_out,
    output logic [TRIG_STATE_W-1:0]  trig_state [CHANNEL_COUNT]
);

    localparam int unsigned CNT_W = phase_cnt_w(PHASE_WIDTH);

    logic             r_ext_d;
    logic             r_man_d;
    logic             r_edge_valid;
    logic [CNT_W-1:0] r_phase_cnt;
    logic             w_ext_rise;
    logic             w_man_rise;
    logic             w_req;
    logic             w_ratio_valid;

    // Previous-value registers clear on reset, so a source already high at
    // release would look like a rising edge. r_edge_valid suppresses the
    // first post-reset cycle until the history registers hold real samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ext_d      <= 1'b0;
            r_man_d      <= 1'b0;
            r_edge_valid <= 1'b0;
        end else begin
            r_ext_d      <= ext_trig;
            r_man_d      <= manual_trig;
            r_edge_valid <= 1'b1;
        end
    end

    // Each source is edge-detected on its own so switching select_trig
    // while a source is high cannot fabricate an edge.
    assign w_ext_rise    = ext_trig    && !r_ext_d && r_edge_valid;
    assign w_man_rise    = manual_trig && !r_man_d && r_edge_valid;
    assign w_req         = select_trig ? w_man_rise : w_ext_rise;
    assign w_ratio_valid = (bsync_ratio != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase_cnt <= '0;
        end else if (bsync_tick) begin
            r_phase_cnt <= '0;
        end else if (r_phase_cnt != '1) begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_ch
        axi_adf4030_trig_channel #(
            .PHASE_WIDTH (PHASE_WIDTH)
        ) u_ch (
            .clk         (clk),
            .rstn        (rstn),
            .req         (w_req),
            .tick        (bsync_tick),
            .phase_cnt   (r_phase_cnt),
            .phase       (trig_channel_phase[g]),
            .en          (trig_channel_en[g]),
            .ready       (bsync_ready),
            .ratio_valid (w_ratio_valid),
            .trig_out    (trig_out[g]),
            .state       (trig_state[g])
        );
    end

endmodule

// File: tb/tb_axi_adf4030_trig_gen.sv
module tb_axi_adf4030_trig_gen;

    localparam int unsigned NCH = 4;
    localparam int unsigned PW  = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic           clk = 1'b0;
    logic           rstn;
    logic           bsync_ready;
    logic           bsync_tick;
    logic [PW-1:0]  bsync_ratio;
    logic           ext_trig;
    logic           manual_trig;
    logic           select_trig;
    logic [NCH-1:0] trig_channel_en;
    logic [PW-1:0]  trig_channel_phase [NCH];
    logic [NCH-1:0] trig_out;
    logic [2:0]     trig_state [NCH];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_adf4030_trig_gen #(
        .CHANNEL_COUNT (NCH),
        .PHASE_WIDTH   (PW)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .bsync_ready        (bsync_ready),
        .bsync_tick         (bsync_tick),
        .bsync_ratio        (bsync_ratio),
        .ext_trig           (ext_trig),
        .manual_trig        (manual_trig),
        .select_trig        (select_trig),
        .trig_channel_en    (trig_channel_en),
        .trig_channel_phase (trig_channel_phase),
        .trig_out           (trig_out),
        .trig_state         (trig_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_states(input string tag, input logic [2:0] exp);
        for (int i = 0; i < NCH; i++)
            chk($sformatf("%s_st%0d", tag, i), trig_state[i], exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Low->high on manual_trig; the request lands on the second edge.
    task automatic arm_manual();
        manual_trig = 1'b0;
        next();
        manual_trig = 1'b1;
        next();
    endtask

    // Tick in the current cycle T, then ncyc cycles; checks trig_out in
    // cycle T+c against a pulse at c == phase+2 for each channel in armed.
    // tper>0 re-issues a tick in cycle T+c whenever c is a multiple of tper.
    task automatic window(input int ncyc, input int tper, input logic [NCH-1:0] armed,
                          input string tag);
        logic [NCH-1:0] exp;
        bsync_tick = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            next();
            bsync_tick = (tper > 0) && (c % tper == 0);
            exp = '0;
            for (int i = 0; i < NCH; i++)
                if (armed[i] && c == int'(trig_channel_phase[i]) + 2) exp[i] = 1'b1;
            chk($sformatf("%s_c%0d", tag, c), trig_out, exp);
        end
        bsync_tick = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        bsync_ready = 1'b1;
        bsync_tick  = 1'b0;
        bsync_ratio = 16'd10;
        ext_trig    = 1'b0;
        manual_trig = 1'b0;
        select_trig = 1'b1;
        trig_channel_en = 4'b0001;
        for (int i = 0; i < NCH; i++) trig_channel_phase[i] = '0;

        // Reset state
        #12;
        chk("rst_out", trig_out, 4'b0000);
        chk_all_states("rst", S_IDLE);
        next();
        rstn = 1'b1;
        next();
        next();

        // Single channel, phase 5, manual held high 4 cycles
        trig_channel_phase[0] = 16'd5;
        manual_trig = 1'b1;
        next();
        chk("t1_armed", trig_state[0], S_ARMED);
        for (int k = 0; k < 3; k++) begin
            next();
            chk($sformatf("t1_hold%0d", k), trig_state[0], S_ARMED);
        end
        manual_trig = 1'b0;
        window(10, 0, 4'b0001, "t1");
        chk("t1_idle", trig_state[0], S_IDLE);

        // Four channels on ext_trig, phases 0/3/3/19, periodic ticks
        trig_channel_en = 4'b1111;
        trig_channel_phase[0] = 16'd0;
        trig_channel_phase[1] = 16'd3;
        trig_channel_phase[2] = 16'd3;
        trig_channel_phase[3] = 16'd19;
        select_trig = 1'b0;
        next();
        ext_trig = 1'b1;
        next();
        chk_all_states("t2_arm", S_ARMED);
        ext_trig = 1'b0;
        window(22, 20, 4'b1111, "t2");
        chk_all_states("t2_end", S_IDLE);

        // Phase beyond the period -> ERROR after next tick, then re-arm
        trig_channel_en = 4'b0001;
        trig_channel_phase[0] = 16'd25;
        select_trig = 1'b1;
        arm_manual();
        chk("t3_armed", trig_state[0], S_ARMED);
        window(21, 20, 4'b0000, "t3");
        chk("t3_error", trig_state[0], S_ERROR);
        arm_manual();
        chk("t3_rearm", trig_state[0], S_ARMED);

        // BSYNC loss during COUNT, then disable
        trig_channel_phase[0] = 16'd5;
        bsync_tick = 1'b1;
        next();
        bsync_tick = 1'b0;
        chk("t4_count", trig_state[0], S_COUNT);
        bsync_ready = 1'b0;
        next();
        chk("t4_error", trig_state[0], S_ERROR);
        chk("t4_out", trig_out, 4'b0000);
        bsync_ready = 1'b1;
        trig_channel_en = 4'b0000;
        next();
        chk("t4_idle", trig_state[0], S_IDLE);
        trig_channel_en = 4'b0001;

        // Disable one cycle before match
        arm_manual();
        chk("t5_armed", trig_state[0], S_ARMED);
        bsync_tick = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next();
            bsync_tick = 1'b0;
        end
        trig_channel_en = 4'b0000;
        next();
        chk("t5_idle", trig_state[0], S_IDLE);
        next();
        chk("t5_nopulse", trig_out, 4'b0000);
        arm_manual();
        chk("t5_en0", trig_state[0], S_IDLE);
        trig_channel_en = 4'b0001;
        bsync_ratio = '0;
        arm_manual();
        chk("t5_ratio0", trig_state[0], S_IDLE);
        bsync_ratio = 16'd10;

        // Switching select while the other source is high is not a req
        manual_trig = 1'b0;
        ext_trig = 1'b1;
        next();
        next();
        select_trig = 1'b0;
        next();
        chk("sel_switch", trig_state[0], S_IDLE);
        ext_trig = 1'b0;
        select_trig = 1'b1;

        // Async reset mid-COUNT; manual left high across release
        arm_manual();
        bsync_tick = 1'b1;
        next();
        bsync_tick = 1'b0;
        chk("t6_count", trig_state[0], S_COUNT);
        next();
        #2 rstn = 1'b0;
        #1;
        chk("t6_out", trig_out, 4'b0000);
        chk_all_states("t6_rst", S_IDLE);
        #2 rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next();
            chk($sformatf("t6_held%0d", k), trig_state[0], S_IDLE);
        end
        arm_manual();
        chk("t6_rearm", trig_state[0], S_ARMED);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_adf4030_trig_gen.md
Name: axi_adf4030_trig_gen

Overview:
- Trigger generator in the `clk` domain, directly downstream of the ADF4030 register map.
- Consumes the per-channel enables and phases, manual trigger and trigger select from the regmap, plus BSYNC timing from the BSYNC capture logic.
- Emits one phase-aligned single-cycle trigger pulse per enabled channel per request.
- Reports per-channel FSM state back to the regmap for its debug registers.

Parameters:
- CHANNEL_COUNT, 1, number of trigger channels; legal range 1..8.
- PHASE_WIDTH, 16, width of the phase and ratio fields.

Ports:
- clk  in  1  core clock; all logic is on rising edge.
- rstn  in  1  asynchronous active-low reset.
- bsync_ready  in  1  BSYNC locked/valid.
- bsync_tick  in  1  one-cycle pulse at the start of each BSYNC period.
- bsync_ratio  in  PHASE_WIDTH  BSYNC half-period in clk cycles; the full period is 2*bsync_ratio.
- ext_trig  in  1  external trigger request, synchronous to clk.
- manual_trig  in  1  synchronized software trigger level; may be high for several cycles.
- select_trig  in  1  request source: 1 = manual_trig, 0 = ext_trig.
- trig_channel_en  in  CHANNEL_COUNT  per-channel enable.
- trig_channel_phase  in  PHASE_WIDTH x CHANNEL_COUNT (unpacked)  firing offset in clk cycles from period start.
- trig_out  out  CHANNEL_COUNT  trigger pulses.
- trig_state  out  3 x CHANNEL_COUNT (unpacked)  per-channel FSM state.

Behaviour:
- Reset (rstn low, async): trig_out=0; every trig_state=IDLE; phase_cnt=0; edge-detect registers cleared.
- Request generation:
  - req = rising edge of the selected source (registered previous value vs current).
  - A source held high produces exactly one req.
  - Changing select_trig must not create a spurious req: both sources are edge-detected independently and then muxed.
- Shared phase counter (PHASE_WIDTH+1 bits):
  - Loads 0 on bsync_tick; otherwise increments, saturating at all-ones.
  - If bsync_tick occurs in cycle T, phase_cnt=0 in cycle T+1.
- Per-channel FSM states: IDLE=0, ARMED=1, COUNT=2, FIRE=3, ERROR=5.
  - IDLE → ARMED: req & en & bsync_ready & (bsync_ratio != 0). Otherwise the req is dropped.
  - ARMED → COUNT: on bsync_tick. A req and a tick in the same cycle in IDLE arm only; the next tick is used.
  - COUNT → FIRE: phase_cnt == zero-extended phase.
  - COUNT → ERROR: bsync_tick arrives before a match. This covers phase >= 2*ratio.
  - FIRE → IDLE: unconditional, after one cycle.
  - ERROR → ARMED: on req, when the IDLE → ARMED conditions hold.
  - ERROR → IDLE: en=0.
- trig_out[i] = (state==FIRE), registered. Latency: tick at T, match at T+1+p, trig_out high for exactly cycle T+2+p.
- Disable: en[i] deasserted in any state → IDLE next cycle, with no pulse. A FIRE already present still completes its single cycle.
- BSYNC loss: bsync_ready low while ARMED or COUNT → ERROR next cycle.
- A req while ARMED, COUNT or FIRE is ignored; there is no queueing.
- phase is sampled continuously during COUNT; a change mid-period takes effect on the next compare.
- All channels share req and phase_cnt, so equal phases fire in the same cycle.
- trig_state is driven directly from the state registers: 0 cycles from state, 1 cycle after the transition condition.

Decomposition:
- Package adf4030_trig_pkg:
  - enum trig_state_t (3-bit, values above);
  - TRIG_STATE_W=3;
  - function for phase compare width (PHASE_WIDTH+1).
- Sub-module axi_adf4030_trig_channel: one FSM plus output register.
  - Inputs: req, tick, phase_cnt, phase, en, ready, ratio_valid.
  - Outputs: trig_out, state.
  - Generated CHANNEL_COUNT times.
- The top level holds the edge detectors, the source mux and the shared counter.

Test Plan:
- Single channel, ratio=10, phase=5, select_trig=1, manual_trig high for 4 cycles → state IDLE→ARMED. Then tick at T → COUNT at T+1, trig_out high only at T+7; exactly one pulse; state back to IDLE at T+8.
- CHANNEL_COUNT=4, phases 0/3/3/19, ratio=10, ext_trig edge with select_trig=0 → pulses at T+2, T+5, T+5, T+21; no ERROR.
- Phase=25, ratio=10 → no pulse; state=ERROR one cycle after the next tick. A further req re-arms (state=ARMED).
- bsync_ready dropped while COUNT → ERROR next cycle, trig_out stays 0. Deasserting en → IDLE.
- en cleared during COUNT one cycle before match → no pulse; state IDLE. A req with en=0, or with ratio=0, stays IDLE.
- Async rstn asserted mid-COUNT (between clock edges) → trig_out=0 and all states IDLE immediately. After release, manual_trig still high produces no req until it toggles low→high.
